// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war game core: game state and round-winner codes.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        ROUND_END = 2'd1,
        MATCH_END = 2'd2
    } tug_state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_RIGHT = 2'b01;
    localparam logic [1:0] WIN_LEFT  = 2'b10;

endpackage

// File: rtl/tug_arena_if.sv
// Player-press and display bundle between the press conditioners, the game core and the displays.
interface tug_arena_if #(
    parameter int N_LIGHTS = 9
) ();

    logic                left_press;
    logic                right_press;
    logic                new_match;
    logic [N_LIGHTS-1:0] lights;
    logic [3:0]          left_score;
    logic [3:0]          right_score;
    logic                round_done;
    logic [1:0]          round_winner;
    logic                match_over;
    logic                match_winner;

    modport master (
        output left_press, right_press, new_match,
        input  lights, left_score, right_score, round_done,
        input  round_winner, match_over, match_winner
    );

    modport slave (
        input  left_press, right_press, new_match,
        output lights, left_score, right_score, round_done,
        output round_winner, match_over, match_winner
    );

endinterface

// File: rtl/tug_arena_hold_timer.sv
// Loadable down-counter that times the blank period between rounds.
module hold_timer #(
    parameter int HOLD_CYCLES = 4,
    parameter int LOAD_VALUE  = HOLD_CYCLES - 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    output logic done
);

    localparam int W = $clog2(HOLD_CYCLES + 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= W'(LOAD_VALUE);
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign done = (r_count == '0);

endmodule

// File: rtl/tug_arena.sv
// Tug-of-war game core: rope position, per-player round scores and best-of match control.
module tug_arena
    import tug_pkg::*;
#(
    parameter int N_LIGHTS    = 9,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    tug_arena_if.slave  bus
);

    localparam int             PW     = $clog2(N_LIGHTS);
    localparam logic [PW-1:0]  CENTER = PW'((N_LIGHTS - 1) / 2);
    localparam logic [PW-1:0]  LAST   = PW'(N_LIGHTS - 1);
    localparam logic [3:0]     WIN    = 4'(WIN_SCORE);

    tug_state_t    r_state;
    logic [PW-1:0] r_pos;
    logic [3:0]    r_left_score;
    logic [3:0]    r_right_score;
    logic          r_round_done;
    logic [1:0]    r_round_winner;
    logic          r_match_winner;

    logic       w_right_only;
    logic       w_left_only;
    logic       w_right_win;
    logic       w_left_win;
    logic [3:0] w_right_next;
    logic [3:0] w_left_next;
    logic       w_timer_load;
    logic       w_timer_done;

    assign w_right_only = bus.right_press & ~bus.left_press;
    assign w_left_only  = bus.left_press & ~bus.right_press;
    assign w_right_win  = (r_state == PLAY) & ~bus.new_match & w_right_only & (r_pos == '0);
    assign w_left_win   = (r_state == PLAY) & ~bus.new_match & w_left_only & (r_pos == LAST);

    assign w_right_next = (r_right_score < WIN) ? r_right_score + 4'd1 : r_right_score;
    assign w_left_next  = (r_left_score < WIN) ? r_left_score + 4'd1 : r_left_score;

    assign w_timer_load = (w_right_win & (w_right_next != WIN)) |
                          (w_left_win & (w_left_next != WIN));

    // The deciding edge already opens the first blank cycle, so the timer runs one short.
    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES),
        .LOAD_VALUE (HOLD_CYCLES - 1)
    ) u_hold_timer (
        .clk  (clk),
        .reset(reset),
        .load (w_timer_load),
        .clear(bus.new_match),
        .done (w_timer_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= PLAY;
            r_pos          <= CENTER;
            r_left_score   <= '0;
            r_right_score  <= '0;
            r_round_done   <= 1'b0;
            r_round_winner <= WIN_NONE;
            r_match_winner <= 1'b0;
        end else begin
            r_round_done <= 1'b0;
            if (bus.new_match) begin
                r_state        <= PLAY;
                r_pos          <= CENTER;
                r_left_score   <= '0;
                r_right_score  <= '0;
                r_round_winner <= WIN_NONE;
                r_match_winner <= 1'b0;
            end else begin
                case (r_state)
                    PLAY: begin
                        if (w_right_win) begin
                            r_right_score  <= w_right_next;
                            r_round_winner <= WIN_RIGHT;
                            r_round_done   <= 1'b1;
                            if (w_right_next == WIN) begin
                                r_state        <= MATCH_END;
                                r_match_winner <= 1'b0;
                            end else begin
                                r_state <= ROUND_END;
                            end
                        end else if (w_left_win) begin
                            r_left_score   <= w_left_next;
                            r_round_winner <= WIN_LEFT;
                            r_round_done   <= 1'b1;
                            if (w_left_next == WIN) begin
                                r_state        <= MATCH_END;
                                r_match_winner <= 1'b1;
                            end else begin
                                r_state <= ROUND_END;
                            end
                        end else if (w_right_only) begin
                            r_pos <= r_pos - PW'(1);
                        end else if (w_left_only) begin
                            r_pos <= r_pos + PW'(1);
                        end
                    end
                    ROUND_END: begin
                        if (w_timer_done) begin
                            r_state <= PLAY;
                            r_pos   <= CENTER;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.lights       = (r_state == PLAY) ? (N_LIGHTS'(1) << r_pos) : '0;
    assign bus.left_score   = r_left_score;
    assign bus.right_score  = r_right_score;
    assign bus.round_done   = r_round_done;
    assign bus.round_winner = r_round_winner;
    assign bus.match_over   = (r_state == MATCH_END);
    assign bus.match_winner = r_match_winner;

endmodule

// File: tb/tb_tug_arena.sv
// Self-checking bench for tug_arena: fixed vectors, hand-written corner sequences and a random walk against a reference model.
module tb_tug_arena;

    localparam int N_LIGHTS    = 9;
    localparam int WIN_SCORE   = 2;
    localparam int HOLD_CYCLES = 3;
    localparam int CENTER      = (N_LIGHTS - 1) / 2;

    typedef struct {
        bit         l;
        bit         r;
        bit         nm;
        logic [8:0] expLights;
        logic [3:0] expLeft;
        logic [3:0] expRight;
        bit         expDone;
        logic [1:0] expWinner;
        bit         expOver;
    } vec_t;

    logic clk;
    logic reset;
    int   checkCount;
    int   passCount;

    int mPos;
    int mLeft;
    int mRight;
    int mPhase;
    int mBlank;
    int mDone;
    int mRoundWinner;
    int mMatchWinner;

    vec_t vecs[11];

    tug_arena_if #(.N_LIGHTS(N_LIGHTS)) bus ();

    tug_arena #(
        .N_LIGHTS   (N_LIGHTS),
        .WIN_SCORE  (WIN_SCORE),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] dutVec();
        return {bus.lights, bus.left_score, bus.right_score, bus.round_done,
                bus.round_winner, bus.match_over, bus.match_winner};
    endfunction

    function automatic logic [21:0] packVec(input logic [8:0] lights, input int ls, input int rs,
                                            input int done, input int rw, input int over, input int mw);
        return {lights, 4'(ls), 4'(rs), 1'(done), 2'(rw), 1'(over), 1'(mw)};
    endfunction

    function automatic logic [21:0] modelVec();
        logic [8:0] lights;
        lights = '0;
        if (mPhase == 0) lights[mPos] = 1'b1;
        return packVec(lights, mLeft, mRight, mDone, mRoundWinner, (mPhase == 2) ? 1 : 0, mMatchWinner);
    endfunction

    // Phases: 0 playing, 1 blank between rounds (mBlank cycles still to show), 2 match decided.
    task automatic modelReset();
        mPos = CENTER;
        mLeft = 0;
        mRight = 0;
        mPhase = 0;
        mBlank = 0;
        mDone = 0;
        mRoundWinner = 0;
        mMatchWinner = 0;
    endtask

    task automatic modelAward(input bit leftWon);
        int score;
        if (leftWon) begin
            mLeft = (mLeft < WIN_SCORE) ? mLeft + 1 : mLeft;
            mRoundWinner = 2;
            score = mLeft;
        end else begin
            mRight = (mRight < WIN_SCORE) ? mRight + 1 : mRight;
            mRoundWinner = 1;
            score = mRight;
        end
        mDone = 1;
        if (score == WIN_SCORE) begin
            mPhase = 2;
            mMatchWinner = leftWon ? 1 : 0;
        end else begin
            mPhase = 1;
            mBlank = HOLD_CYCLES;
        end
    endtask

    task automatic modelStep(input bit l, input bit r, input bit nm);
        mDone = 0;
        if (nm) begin
            modelReset();
        end else if (mPhase == 0) begin
            if (r && !l) begin
                if (mPos > 0) mPos = mPos - 1;
                else modelAward(1'b0);
            end else if (l && !r) begin
                if (mPos < N_LIGHTS - 1) mPos = mPos + 1;
                else modelAward(1'b1);
            end
        end else if (mPhase == 1) begin
            mBlank = mBlank - 1;
            if (mBlank == 0) begin
                mPhase = 0;
                mPos = CENTER;
            end
        end
    endtask

    task automatic applyStimulus(input bit l, input bit r, input bit nm);
        bus.left_press  = l;
        bus.right_press = r;
        bus.new_match   = nm;
        modelStep(l, r, nm);
        @(posedge clk);
        #1;
        bus.left_press  = 1'b0;
        bus.right_press = 1'b0;
        bus.new_match   = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [21:0] act, input logic [21:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got lights=%b ls=%0d rs=%0d done=%b rw=%b over=%b mw=%b, expected lights=%b ls=%0d rs=%0d done=%b rw=%b over=%b mw=%b",
                     name, act[21:13], act[12:9], act[8:5], act[4], act[3:2], act[1], act[0],
                     exp[21:13], exp[12:9], exp[8:5], exp[4], exp[3:2], exp[1], exp[0]);
        end else begin
            passCount++;
        end
    endtask

    initial begin
        logic [21:0] centreIdle;
        bit          biasLeft;
        checkCount = 0;
        passCount  = 0;
        centreIdle = packVec(9'b000010000, 0, 0, 0, 0, 0, 0);

        vecs[0]  = '{0, 1, 0, 9'b000001000, 4'd0, 4'd0, 0, 2'b00, 0};
        vecs[1]  = '{0, 1, 0, 9'b000000100, 4'd0, 4'd0, 0, 2'b00, 0};
        vecs[2]  = '{0, 1, 0, 9'b000000010, 4'd0, 4'd0, 0, 2'b00, 0};
        vecs[3]  = '{0, 1, 0, 9'b000000001, 4'd0, 4'd0, 0, 2'b00, 0};
        vecs[4]  = '{1, 1, 0, 9'b000000001, 4'd0, 4'd0, 0, 2'b00, 0};
        vecs[5]  = '{0, 1, 0, 9'b000000000, 4'd0, 4'd1, 1, 2'b01, 0};
        vecs[6]  = '{0, 0, 0, 9'b000000000, 4'd0, 4'd1, 0, 2'b01, 0};
        vecs[7]  = '{1, 0, 0, 9'b000000000, 4'd0, 4'd1, 0, 2'b01, 0};
        vecs[8]  = '{0, 1, 0, 9'b010000000 >> 3, 4'd0, 4'd1, 0, 2'b01, 0};
        vecs[9]  = '{1, 1, 0, 9'b000010000, 4'd0, 4'd1, 0, 2'b01, 0};
        vecs[10] = '{1, 0, 0, 9'b000100000, 4'd0, 4'd1, 0, 2'b01, 0};

        reset = 1'b1;
        bus.left_press  = 1'b0;
        bus.right_press = 1'b0;
        bus.new_match   = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_values", dutVec(), centreIdle);
        #6;
        reset = 1'b0;

        // Rope walk to the right edge, edge tie, round win, blank with a stray press, return to centre.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].l, vecs[i].r, vecs[i].nm);
            checkOutput($sformatf("vector_%0d", i), dutVec(),
                        packVec(vecs[i].expLights, vecs[i].expLeft, vecs[i].expRight,
                                vecs[i].expDone, vecs[i].expWinner, vecs[i].expOver, 0));
        end

        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("new_match_clear", dutVec(), centreIdle);

        // Right takes two rounds and the match; later presses must be ignored.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("first_round_right", dutVec(), packVec(9'b0, 0, 1, 1, 1, 0, 0));
        for (int i = 0; i < HOLD_CYCLES; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("back_to_centre", dutVec(), packVec(9'b000010000, 0, 1, 0, 1, 0, 0));
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("match_won_right", dutVec(), packVec(9'b0, 0, 2, 1, 1, 1, 0));
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("match_end_holds", dutVec(), packVec(9'b0, 0, 2, 0, 1, 1, 0));
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("new_match_priority", dutVec(), centreIdle);

        // Asynchronous reset during the second blank cycle.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("second_blank_cycle", dutVec(), packVec(9'b0, 0, 1, 0, 1, 0, 0));
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_mid_hold", dutVec(), centreIdle);
        modelReset();
        #3;
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("play_after_reset", dutVec(), packVec(9'b000100000, 0, 0, 0, 0, 0, 0));

        // Random play in biased epochs so both players win rounds and matches.
        biasLeft = 1'b0;
        for (int i = 0; i < 800; i++) begin
            bit l;
            bit r;
            bit nm;
            if (i % 40 == 0) biasLeft = $urandom_range(0, 1) == 1;
            l  = biasLeft ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 2);
            r  = biasLeft ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 6);
            nm = $urandom_range(0, 59) == 0;
            applyStimulus(l, r, nm);
            checkOutput($sformatf("random_%0d", i), dutVec(), modelVec());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/tug_arena.md
# tug_arena

Parametrised tug-of-war game core: the successor to the fixed 9-light chain of per-LED cells and the separate victory block. It holds the rope position as a binary index over `N_LIGHTS` positions, drives a one-hot light vector, keeps per-player round scores and plays a best-of match to `WIN_SCORE`. It sits between the per-player press conditioners (metastability filter plus single-pulse stage, human or computer player) and the LED and 7-segment display logic.

## Interface
- `N_LIGHTS`, 9 — number of rope positions; must be odd, 3..31; the centre is index `(N_LIGHTS-1)/2`.
- `WIN_SCORE`, 7 — number of rounds needed to win the match; range 1..15.
- `HOLD_CYCLES`, 4 — number of cycles the round-end blank lasts; must be ≥ 1.
- `clk`  in  1  — the single clock (the divided game clock).
- `reset`  in  1  — asynchronous, active-high; clears all state.
- `left_press`  in  1  — single-cycle, already synchronised pulse; moves the rope toward index `N_LIGHTS-1`.
- `right_press`  in  1  — single-cycle pulse; moves the rope toward index 0.
- `new_match`  in  1  — single-cycle pulse; restarts the match.
- `lights`  out  N_LIGHTS  — one-hot rope position, or all zero while blanked.
- `left_score`  out  4  — rounds won by the left player.
- `right_score`  out  4  — rounds won by the right player.
- `round_done`  out  1  — one-cycle pulse when a round is decided.
- `round_winner`  out  2  — 2'b00 none, 2'b01 right, 2'b10 left; held until the next round is decided.
- `match_over`  out  1  — high while in MATCH_END.
- `match_winner`  out  1  — 1 = left, 0 = right; valid only while `match_over` is high.

## Operation
- States: PLAY, ROUND_END, MATCH_END.
- **PLAY**, one press only:
  - `right_press` with pos > 0: pos decrements.
  - `left_press` with pos < N_LIGHTS-1: pos increments.
- **Round win**:
  - `right_press` at pos 0 gives the right player the round.
  - `left_press` at pos N_LIGHTS-1 gives the left player the round.
  - On a round win: the winner's score increments, `round_winner` is set and `round_done` pulses.
  - If the new score equals `WIN_SCORE`, go to MATCH_END; otherwise go to ROUND_END and load the hold timer with `HOLD_CYCLES`.
- **Both presses in the same cycle**: no movement and no score change, including at an edge.
- **ROUND_END**:
  - `lights` = 0 and presses are ignored.
  - The timer decrements every cycle; when it reaches 0, pos returns to centre and the state returns to PLAY.
- **MATCH_END**:
  - `lights` = 0, `match_over` = 1 and `match_winner` is set; presses are ignored.
  - The state is held until `new_match` or `reset`.
- **`new_match`**: honoured in any state and takes priority over presses in the same cycle. It clears both scores and `round_winner`, sets pos to centre, sets the state to PLAY and clears the timer.
- **Scores**: saturate at `WIN_SCORE`; they never wrap.
- **Reset values** (all outputs):
  - `lights` = one-hot centre (9'b000010000 for N_LIGHTS = 9).
  - Scores = 0.
  - `round_done` = 0, `round_winner` = 2'b00.
  - `match_over` = 0, `match_winner` = 0.
  - State = PLAY, timer = 0.

## Timing
- All outputs are registered.
- A press sampled at edge k is reflected in `lights` and the scores after edge k.
- `round_done` is high for exactly the cycle after the deciding edge.
- `lights` blanks on that same cycle.
- In ROUND_END, `lights` is zero for exactly `HOLD_CYCLES` cycles; the centre light shows on cycle `HOLD_CYCLES+1`, and presses are accepted from that cycle onward.
- A reset asserted mid-round or mid-hold forces the reset values immediately, without waiting for a clock edge.

## Structure
- Package `tug_pkg`: state enum `tug_state_t` (PLAY, ROUND_END, MATCH_END) and the winner encodings `WIN_NONE`, `WIN_RIGHT`, `WIN_LEFT`.
- Sub-module `hold_timer`:
  - Loadable down-counter of width `$clog2(HOLD_CYCLES+1)`.
  - Inputs: `load`. Output: `done`, asserted when the count is zero.
  - Same `clk`/`reset` as the parent.
- `lights` is decoded from the pos register: `(1 << pos)`, gated by state == PLAY.

## Test plan
Parameters: N_LIGHTS = 9, WIN_SCORE = 2, HOLD_CYCLES = 3.
1. Reset -> `lights` = 9'b000010000, both scores 0, `match_over` = 0.
2. Four `right_press` pulses -> `lights` = 9'b000000001. A fifth pulse -> `round_done` pulses once, `round_winner` = 01, `right_score` = 1, `lights` = 0 for 3 cycles, then `lights` = 9'b000010000.
3. `left_press` and `right_press` in the same cycle, at centre and at pos 0 -> `lights` and scores unchanged.
4. Presses during ROUND_END -> no effect; the rope returns exactly to centre.
5. Right wins two rounds -> `match_over` = 1, `match_winner` = 0, `right_score` = 2, `lights` = 0; later presses are ignored. `new_match` -> next cycle: scores 0, `round_winner` = 00, `lights` = centre.
6. `reset` asserted in the second cycle of ROUND_END -> outputs reach the reset values before the next clock edge; after release, play resumes at centre.
